// File: rtl/ifu_if.sv
// Fetch-unit bus bundle: redirect/stall control, instruction-memory port and decode-side outputs.
// Purely structural; carries no state and adds no latency.
// Backpressure is expressed by stall (decode side) and imem_gnt (memory side).
interface ifu_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic        inst_fault;

  // The fetch unit side.
  modport master (
    input  redirect, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata, imem_err,
    output imem_req, imem_addr, inst, inst_valid, pc, inst_fault
  );

  // The environment side: memory, decode and redirect sources.
  modport slave (
    output redirect, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata, imem_err,
    input  imem_req, imem_addr, inst, inst_valid, pc, inst_fault
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC, issues word fetches, queues responses in order.
// Latency: a response written at edge N is visible to decode in cycle N+1 (no bypass).
// Backpressure: requests are credit-limited (queued + outstanding < QDEPTH); stall holds the head.
module ifu #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int unsigned QDEPTH    = 2
) (
  input  logic clk,
  input  logic rstn,
  ifu_if.master bus
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [CW:0] QD_C = (CW + 1)'(QDEPTH);

  logic [31:0]   fpc;
  logic [31:0]   dpc;
  logic [CW-1:0] occ;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   q_data [QDEPTH];
  logic          q_err  [QDEPTH];

  logic [CW:0]   credit;
  logic          req;
  logic          fire;
  logic          push;
  logic          pop;
  logic          rsp_drop;
  logic          head_vld;
  logic [31:0]   rpc_al;

  // Credits count both queued entries and responses still owed, so a push can never overflow.
  assign credit   = {1'b0, occ} + {1'b0, outst};
  // Gating with rstn keeps the request low for the whole reset window.
  assign req      = rstn && !bus.redirect && (credit < QD_C);
  assign fire     = req && bus.imem_gnt;
  assign head_vld = (occ != '0);
  assign pop      = head_vld && !bus.stall;
  assign rsp_drop = bus.imem_rvalid && (drop != '0);
  assign push     = bus.imem_rvalid && !bus.redirect && (drop == '0);
  assign rpc_al   = bus.redirect_pc & 32'hFFFF_FFFC;

  // PCs, counters and queue pointers; redirect overrides every other update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fpc    <= BOOT_ADDR;
      dpc    <= BOOT_ADDR;
      occ    <= '0;
      outst  <= '0;
      drop   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (bus.redirect) begin
      fpc    <= rpc_al;
      dpc    <= rpc_al;
      occ    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      // Everything still owed is stale, except a response landing right now (discarded here).
      outst  <= outst - CW'(bus.imem_rvalid);
      drop   <= outst - CW'(bus.imem_rvalid);
    end else begin
      if (fire) fpc <= fpc + 32'd4;
      if (pop) begin
        dpc    <= dpc + 32'd4;
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (rsp_drop) drop <= drop - CW'(1);
      outst <= outst + CW'(fire) - CW'(bus.imem_rvalid);
      occ   <= occ + CW'(push) - CW'(pop);
    end
  end

  // Queue storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= bus.imem_rdata;
      q_err[wr_ptr]  <= bus.imem_err;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fpc;
  assign bus.inst_valid = head_vld;
  assign bus.inst       = head_vld ? q_data[rd_ptr] : 32'h0;
  assign bus.inst_fault = head_vld && q_err[rd_ptr];
  assign bus.pc         = dpc;

endmodule
